lcd_sequencer: RTL and testbench
================================

LCD_SEQUENCER -- requirements
Module: lcd_sequencer

Interface
REQ-001 Parameter SETUP_CYC, default 2: clocks with RS/RW/data stable and LCD_E low before the E rising edge (tAS).
REQ-002 Parameter E_HIGH_CYC, default 12: clocks LCD_E is held high per bus cycle (PWEH).
REQ-003 Parameter HOLD_CYC, default 2: clocks with RS/RW/data held after the E falling edge (tAH).
REQ-004 Parameter POR_WAIT_CYC, default 750000: power-on wait before the first init command (15 ms at 50 MHz).
REQ-005 Parameter BUSY_TIMEOUT, default 100000: maximum clocks spent in busy polling for one command.
REQ-006 clk  input  1  single clock; all logic on its rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 req_valid  input  1  requester has a byte to send.
REQ-009 req_rs  input  1  0 = instruction, 1 = data (DDRAM/CGRAM write).
REQ-010 req_data  input  8  byte to write.
REQ-011 req_ready  output  1  sequencer can accept a request this cycle.
REQ-012 init_done  output  1  power-on init sequence complete; stays high until reset.
REQ-013 busy_timeout  output  1  one-cycle pulse when busy polling exceeds BUSY_TIMEOUT.
REQ-014 LCD_E  output  1  LCD enable strobe.
REQ-015 LCD_RS  output  1  LCD register select.
REQ-016 LCD_RW  output  1  LCD read/write (1 = read).
REQ-017 LCD_data  inout  8  LCD data bus; driven only in write phases, high-Z otherwise.

Function
REQ-018 States SHALL be: POR_WAIT, INIT_LOAD, IDLE, W_SETUP, W_EHIGH, W_HOLD, P_SETUP, P_EHIGH, P_HOLD.
REQ-019 POR_WAIT: count POR_WAIT_CYC clocks, then go to INIT_LOAD.
REQ-020 INIT_LOAD: issue ROM commands 0x38, 0x0C, 0x01, 0x06 in order, RS=0, each as a full write cycle plus busy poll; init_done is set the cycle after the poll of 0x06 ends.
REQ-021 req_ready = 1 only in IDLE with init_done = 1; a request is accepted when req_valid & req_ready; req_rs/req_data are registered on acceptance.
REQ-022 Write cycle: W_SETUP for SETUP_CYC clocks (E=0, RW=0, RS=byte type, bus driven), then W_EHIGH for E_HIGH_CYC clocks (E=1), then W_HOLD for HOLD_CYC clocks (E=0, bus still driven), then P_SETUP.
REQ-023 Busy poll: P_SETUP SETUP_CYC clocks (RS=0, RW=1, bus high-Z, E=0); P_EHIGH E_HIGH_CYC clocks (E=1), sample LCD_data[7] on the last E-high clock; P_HOLD HOLD_CYC clocks (E=0).
REQ-024 After P_HOLD: if the sampled BF=1, repeat P_SETUP; if BF=0, go to IDLE, or to the next INIT_LOAD command during init.
REQ-025 LCD_data SHALL never be driven while RW=1; RW SHALL change only while E=0.
REQ-026 Timeout counter starts at 0 on entry to the first P_SETUP of a command and increments every poll-state clock; when it reaches BUSY_TIMEOUT, the FSM ends polling at the next E-low point (never mid-E-high), pulses busy_timeout for 1 clock, and proceeds as if BF=0.
REQ-027 A request arriving while req_ready=0 SHALL be held off (not dropped); the requester keeps req_valid asserted.
REQ-028 Accept-to-first-E-high latency SHALL be 1 + SETUP_CYC clocks.
REQ-029 All outputs SHALL be registered.

Reset
REQ-030 While reset=1, at the next edge: state=POR_WAIT, LCD_E=0, LCD_RS=0, LCD_RW=0, bus high-Z, req_ready=0, init_done=0, busy_timeout=0, all counters 0.
REQ-031 Reset mid-cycle (including during E-high) SHALL drop LCD_E on the next clock and restart the full POR and init sequence.

Verification (SETUP_CYC=2, E_HIGH_CYC=4, HOLD_CYC=2, POR_WAIT_CYC=20, BUSY_TIMEOUT=40; LCD model returns BF per test)
REQ-032 Reset, BF=0 -> 20 clocks idle, then 4 write cycles with bytes 0x38/0x0C/0x01/0x06 and RS=0, each followed by one poll; then init_done=1 and req_ready=1.
REQ-033 After init, req_rs=1 and req_data=0x41 -> E rises 3 clocks after accept; bus=0x41 and RS=1 stable from 2 clocks before E rises to 2 clocks after E falls; E high for exactly 4 clocks.
REQ-034 BF=1 for 2 polls then 0 -> exactly 3 poll cycles; RW=1 and bus high-Z throughout; then req_ready=1.
REQ-035 BF stuck at 1 -> busy_timeout pulses exactly once, E low at the pulse, FSM returns to IDLE.
REQ-036 reset asserted during W_EHIGH -> E=0 on the next clock, init_done=0, full init sequence repeats.
REQ-037 req_valid held during polling -> not accepted until IDLE; byte sent exactly once.

Source files
------------

// File: rtl/lcd_sequencer.sv
// HD44780-style LCD bus sequencer: power-on wait, init ROM, write cycles with busy-flag polling.
// All bus outputs are a registered decode of the current state, so each phase appears one clock after the state enters it.
module lcd_sequencer #(
    parameter int unsigned SETUP_CYC    = 2,
    parameter int unsigned E_HIGH_CYC   = 12,
    parameter int unsigned HOLD_CYC     = 2,
    parameter int unsigned POR_WAIT_CYC = 750000,
    parameter int unsigned BUSY_TIMEOUT = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    input  logic       req_rs,
    input  logic [7:0] req_data,
    output logic       req_ready,
    output logic       init_done,
    output logic       busy_timeout,
    output logic       LCD_E,
    output logic       LCD_RS,
    output logic       LCD_RW,
    inout  wire  [7:0] LCD_data
);

    localparam int unsigned PH_A   = (SETUP_CYC > E_HIGH_CYC) ? SETUP_CYC : E_HIGH_CYC;
    localparam int unsigned PH_B   = (HOLD_CYC > POR_WAIT_CYC) ? HOLD_CYC : POR_WAIT_CYC;
    localparam int unsigned PH_MAX = (PH_A > PH_B) ? PH_A : PH_B;
    localparam int unsigned CNT_W  = $clog2(PH_MAX + 1);
    localparam int unsigned TO_W   = $clog2(BUSY_TIMEOUT + 1);

    typedef enum logic [3:0] {
        POR_WAIT,
        INIT_LOAD,
        IDLE,
        W_SETUP,
        W_EHIGH,
        W_HOLD,
        P_SETUP,
        P_EHIGH,
        P_HOLD
    } state_e;

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [TO_W-1:0]   to_cnt_q;
    logic [1:0]        rom_idx_q;
    logic [7:0]        byte_q;
    logic              rs_q;
    logic              bf_q;
    logic              req_ready_q;
    logic              init_done_q;
    logic              busy_to_q;
    logic              e_q;
    logic              rs_out_q;
    logic              rw_q;
    logic              oe_q;
    logic [7:0]        dout_q;

    logic              phase_last_c;
    logic              timed_out_c;
    logic              bf_c;
    logic              poll_exit_c;
    logic              poll_to_c;
    logic              write_st_c;
    logic              poll_st_c;

    function automatic logic [7:0] init_rom(input logic [1:0] idx);
        case (idx)
            2'd0:    init_rom = 8'h38;
            2'd1:    init_rom = 8'h0C;
            2'd2:    init_rom = 8'h01;
            default: init_rom = 8'h06;
        endcase
    endfunction

    // Phase-end, busy-flag and poll-exit decisions for the current state
    always_comb begin
        phase_last_c = 1'b0;
        poll_exit_c  = 1'b0;
        poll_to_c    = 1'b0;
        write_st_c   = (state_q == W_SETUP) || (state_q == W_EHIGH) || (state_q == W_HOLD);
        poll_st_c    = (state_q == P_SETUP) || (state_q == P_EHIGH) || (state_q == P_HOLD);
        timed_out_c  = (to_cnt_q >= TO_W'(BUSY_TIMEOUT - 1));
        bf_c         = (cnt_q == '0) ? LCD_data[7] : bf_q;
        case (state_q)
            POR_WAIT:         phase_last_c = (cnt_q == CNT_W'(POR_WAIT_CYC - 1));
            W_SETUP, P_SETUP: phase_last_c = (cnt_q == CNT_W'(SETUP_CYC - 1));
            W_EHIGH, P_EHIGH: phase_last_c = (cnt_q == CNT_W'(E_HIGH_CYC - 1));
            W_HOLD, P_HOLD:   phase_last_c = (cnt_q == CNT_W'(HOLD_CYC - 1));
            default:          phase_last_c = 1'b0;
        endcase
        // Polling only ends while E is low: at the start of a setup phase or at the end of hold
        if (state_q == P_SETUP && timed_out_c) begin
            poll_exit_c = 1'b1;
            poll_to_c   = 1'b1;
        end else if (state_q == P_HOLD && phase_last_c) begin
            if (!bf_c) begin
                poll_exit_c = 1'b1;
            end else if (timed_out_c) begin
                poll_exit_c = 1'b1;
                poll_to_c   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= POR_WAIT;
            cnt_q       <= '0;
            to_cnt_q    <= '0;
            rom_idx_q   <= '0;
            byte_q      <= '0;
            rs_q        <= 1'b0;
            bf_q        <= 1'b0;
            req_ready_q <= 1'b0;
            init_done_q <= 1'b0;
            busy_to_q   <= 1'b0;
            e_q         <= 1'b0;
            rs_out_q    <= 1'b0;
            rw_q        <= 1'b0;
            oe_q        <= 1'b0;
            dout_q      <= '0;
        end else begin
            e_q       <= (state_q == W_EHIGH) || (state_q == P_EHIGH);
            rw_q      <= poll_st_c;
            oe_q      <= write_st_c;
            rs_out_q  <= write_st_c ? rs_q : 1'b0;
            dout_q    <= byte_q;
            busy_to_q <= poll_to_c;

            if (poll_st_c && to_cnt_q != TO_W'(BUSY_TIMEOUT)) begin
                to_cnt_q <= to_cnt_q + TO_W'(1);
            end

            if (poll_exit_c) begin
                cnt_q <= '0;
                if (init_done_q || rom_idx_q == 2'd3) begin
                    state_q     <= IDLE;
                    init_done_q <= 1'b1;
                    req_ready_q <= 1'b1;
                end else begin
                    state_q   <= INIT_LOAD;
                    rom_idx_q <= rom_idx_q + 2'd1;
                end
            end else begin
                cnt_q <= phase_last_c ? '0 : cnt_q + CNT_W'(1);
                case (state_q)
                    POR_WAIT: if (phase_last_c) state_q <= INIT_LOAD;
                    INIT_LOAD: begin
                        byte_q  <= init_rom(rom_idx_q);
                        rs_q    <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= W_SETUP;
                    end
                    IDLE: begin
                        cnt_q <= '0;
                        if (req_valid && req_ready_q) begin
                            byte_q      <= req_data;
                            rs_q        <= req_rs;
                            req_ready_q <= 1'b0;
                            state_q     <= W_SETUP;
                        end
                    end
                    W_SETUP: if (phase_last_c) state_q <= W_EHIGH;
                    W_EHIGH: if (phase_last_c) state_q <= W_HOLD;
                    W_HOLD: begin
                        if (phase_last_c) begin
                            to_cnt_q <= '0;
                            state_q  <= P_SETUP;
                        end
                    end
                    P_SETUP: if (phase_last_c) state_q <= P_EHIGH;
                    P_EHIGH: if (phase_last_c) state_q <= P_HOLD;
                    P_HOLD: begin
                        // First hold clock is the edge that ends the last E-high clock
                        if (cnt_q == '0) bf_q <= LCD_data[7];
                        if (phase_last_c) state_q <= P_SETUP;
                    end
                    default: state_q <= POR_WAIT;
                endcase
            end
        end
    end

    assign req_ready    = req_ready_q;
    assign init_done    = init_done_q;
    assign busy_timeout = busy_to_q;
    assign LCD_E        = e_q;
    assign LCD_RS       = rs_out_q;
    assign LCD_RW       = rw_q;
    assign LCD_data     = oe_q ? dout_q : 8'bzzzz_zzzz;

endmodule

// File: tb/tb_lcd_sequencer.sv
// Randomized scoreboard bench for lcd_sequencer with a behavioural LCD busy-flag model.
module tb_lcd_sequencer;

    localparam int unsigned SETUP     = 2;
    localparam int unsigned EH        = 4;
    localparam int unsigned HOLD      = 2;
    localparam int unsigned POR       = 20;
    localparam int unsigned TO        = 40;
    localparam int unsigned POLL_LEN  = SETUP + EH + HOLD;
    localparam int unsigned MAX_POLLS = (TO + POLL_LEN - 1) / POLL_LEN;
    localparam int          STUCK     = 1000;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_rs = 1'b0;
    logic [7:0] req_data = 8'h00;
    logic       req_ready, init_done, busy_timeout, LCD_E, LCD_RS, LCD_RW;
    wire  [7:0] LCD_data;

    typedef struct {
        logic       rs;
        logic [7:0] data;
        int         busy;
        int         acc;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   busy_left = 0;

    // LCD model answers reads with BF set while it still has busy polls left
    assign LCD_data = LCD_RW ? {(busy_left > 0), 7'h00} : 8'bzzzz_zzzz;

    lcd_sequencer #(
        .SETUP_CYC(SETUP), .E_HIGH_CYC(EH), .HOLD_CYC(HOLD),
        .POR_WAIT_CYC(POR), .BUSY_TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_rs(req_rs),
        .req_data(req_data), .req_ready(req_ready), .init_done(init_done),
        .busy_timeout(busy_timeout), .LCD_E(LCD_E), .LCD_RS(LCD_RS),
        .LCD_RW(LCD_RW), .LCD_data(LCD_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: one poll per busy response plus the final ready poll, capped by the timeout
    function automatic int exp_polls(input int busy);
        return (busy + 1 < int'(MAX_POLLS)) ? busy + 1 : int'(MAX_POLLS);
    endfunction

    function automatic int exp_to(input int busy);
        return (busy >= int'(MAX_POLLS)) ? 1 : 0;
    endfunction

    // ---------------- monitor ----------------
    logic       prev_e = 1'b0, prev_rw = 1'b0, prev_ready = 1'b0;
    logic       h_e[8], h_rw[8], h_rs[8];
    logic [7:0] h_d[8];
    int         e_len = 0, hold_left = 0;
    logic       hold_ok, hold_rs;
    logic [7:0] hold_d;
    bit         pend = 0;
    int         pend_polls = 0, pend_to = 0, pend_busy = 0;

    task automatic finalize();
        if (pend) begin
            check("poll_count", pend_polls, exp_polls(pend_busy));
            check("timeout_pulses", pend_to, exp_to(pend_busy));
            pend = 0;
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            prev_e = 1'b0; prev_rw = 1'b0; prev_ready = 1'b0;
            e_len = 0; hold_left = 0;
        end else begin
            if (LCD_RW !== prev_rw) check("rw_change_with_e_low", {prev_e, LCD_E}, 0);
            if (LCD_E && !prev_e) begin
                e_len = 1;
                if (!LCD_RW) begin
                    finalize();
                    if (exp_q.size() == 0) begin
                        check("unexpected_write", LCD_data, -1);
                    end else begin
                        exp_t cur;
                        bit   ok;
                        cur = exp_q.pop_front();
                        check("write_rs", LCD_RS, cur.rs);
                        check("write_data", LCD_data, cur.data);
                        if (cur.acc >= 0) check("accept_to_e_latency", cyc - cur.acc, 1 + SETUP);
                        ok = 1;
                        for (int i = 0; i < int'(SETUP); i++)
                            if (h_e[i] !== 1'b0 || h_rw[i] !== 1'b0 || h_rs[i] !== cur.rs || h_d[i] !== cur.data) ok = 0;
                        check("write_setup_stable", ok, 1);
                        busy_left = cur.busy;
                        pend = 1; pend_polls = 0; pend_to = 0; pend_busy = cur.busy;
                    end
                end else begin
                    pend_polls++;
                    check("poll_rs_low", LCD_RS, 0);
                end
            end else if (LCD_E) begin
                e_len++;
            end
            if (!LCD_E && prev_e) begin
                check("e_high_len", e_len, EH);
                if (!LCD_RW) begin
                    hold_left = HOLD; hold_ok = 1'b1; hold_rs = h_rs[0]; hold_d = h_d[0];
                end else if (busy_left > 0 && busy_left < STUCK) begin
                    busy_left--;
                end
            end
            if (hold_left > 0) begin
                if (LCD_RS !== hold_rs || LCD_data !== hold_d || LCD_RW !== 1'b0 || LCD_E !== 1'b0) hold_ok = 1'b0;
                hold_left--;
                if (hold_left == 0) check("write_hold_stable", hold_ok, 1);
            end
            if (busy_timeout) begin
                pend_to++;
                check("timeout_with_e_low", LCD_E, 0);
            end
            if (req_ready && !prev_ready) finalize();
            for (int i = 7; i > 0; i--) begin
                h_e[i] = h_e[i-1]; h_rw[i] = h_rw[i-1]; h_rs[i] = h_rs[i-1]; h_d[i] = h_d[i-1];
            end
            h_e[0] = LCD_E; h_rw[0] = LCD_RW; h_rs[0] = LCD_RS; h_d[0] = LCD_data;
            prev_e = LCD_E; prev_rw = LCD_RW; prev_ready = req_ready;
        end
    end

    // ---------------- stimulus ----------------
    task automatic push_init();
        logic [7:0] rom [4];
        rom[0] = 8'h38; rom[1] = 8'h0C; rom[2] = 8'h01; rom[3] = 8'h06;
        for (int i = 0; i < 4; i++) begin
            exp_t e;
            e.rs = 1'b0; e.data = rom[i]; e.busy = 0; e.acc = -1;
            exp_q.push_back(e);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); @(negedge clk);
        check("reset_e_drop", LCD_E, 0);
        check("reset_outputs", {LCD_E, LCD_RS, LCD_RW, req_ready, init_done, busy_timeout}, 0);
        @(posedge clk); @(negedge clk);
        exp_q.delete();
        pend = 0; busy_left = 0; req_valid = 1'b0;
        push_init();
        reset = 1'b0;
    endtask

    task automatic wait_ready(input int bound);
        int n = 0;
        while (!req_ready && n < bound) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", req_ready, 1);
        check("init_done_at_ready", init_done, 1);
    endtask

    task automatic send(input logic rs, input logic [7:0] d, input int busy, input bit keep);
        int n = 0;
        req_valid = 1'b1; req_rs = rs; req_data = d;
        while (!req_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("accept_wait", req_ready, 1);
        if (req_ready) begin
            exp_t e;
            e.rs = rs; e.data = d; e.busy = busy; e.acc = cyc + 1;
            exp_q.push_back(e);
        end
        @(negedge clk);
        if (!keep) begin
            req_valid = 1'b0;
            repeat ($urandom_range(0, 5)) @(negedge clk);
        end
    endtask

    initial begin
        int n;
        @(negedge clk);
        do_reset();
        n = 0;
        while (!LCD_E && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("por_wait_window", (n >= int'(POR)) && (n <= int'(POR + SETUP + 4)), 1);
        wait_ready(2000);

        send(1'b1, 8'h41, 0, 1'b0);
        send(1'b0, 8'hC0, 2, 1'b0);
        send(1'b1, 8'h5A, STUCK, 1'b1);
        send(1'b0, 8'h80, 4, 1'b0);
        wait_ready(2000);

        // Reset while E is high on a data write, then the full init must repeat
        send(1'b1, 8'h55, 0, 1'b0);
        n = 0;
        while (!LCD_E && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("e_rise_before_reset", LCD_E, 1);
        do_reset();
        check("init_done_cleared", init_done, 0);
        wait_ready(2000);

        for (int i = 0; i < 24; i++) begin
            int   r, busy;
            r = $urandom_range(0, 9);
            if (r < 4)      busy = 0;
            else if (r < 7) busy = $urandom_range(1, 3);
            else if (r < 9) busy = int'(MAX_POLLS) - 1;
            else            busy = STUCK;
            send(1'($urandom_range(0, 1)), 8'($urandom), busy, $urandom_range(0, 2) == 0);
        end
        req_valid = 1'b0;
        wait_ready(2000);
        repeat (4) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
